// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shifter, MSB first.
// Takes a WIDTH-bit word over a valid/ready handshake and emits one bit per
// clock. Back-to-back frames are sent with no idle gap: the next word is
// accepted on the edge that retires the last bit of the current frame.
// Optional build macro SERIALIZER_PARITY_EN appends one even-parity bit
// (XOR of the accepted word) to every frame.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no frame in progress, ready for a word
// SHIFT  | data bits on the wire; cnt is the index of the bit now on out
// PARITY | parity bit on the wire (SERIALIZER_PARITY_EN only)

module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept;
  logic             last_bit;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  // The serial bit is the shift register MSB, so it comes straight off a flop.
  assign out      = sreg[WIDTH-1];
  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign accept   = din_valid && din_ready;

  // Ready is the only combinational output; held low while reset is asserted.
  always_comb begin
    din_ready = 1'b0;
    if (!reset) begin
`ifdef SERIALIZER_PARITY_EN
      din_ready = (state == IDLE) || (state == PARITY);
`else
      din_ready = (state == IDLE) || last_bit;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = SHIFT;
      SHIFT: begin
        if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
          state_n = PARITY;
`else
          state_n = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: state_n = accept ? SHIFT : IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Shift register and bit counter next values; a finished frame leaves the
  // register all zeros, which is what drives out low while idle.
  always_comb begin
    sreg_n = sreg;
    cnt_n  = cnt;
    if (accept) begin
      sreg_n = din;
      cnt_n  = '0;
    end else if (state == SHIFT) begin
      cnt_n = last_bit ? '0 : cnt + CW'(1);
`ifdef SERIALIZER_PARITY_EN
      sreg_n = last_bit ? {par_q, {(WIDTH-1){1'b0}}} : {sreg[WIDTH-2:0], 1'b0};
`else
      sreg_n = {sreg[WIDTH-2:0], 1'b0};
`endif
    end
`ifdef SERIALIZER_PARITY_EN
    else if (state == PARITY) begin
      sreg_n = '0;
    end
`endif
  end

  // Datapath and status flops; status reflects the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg        <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sreg        <= sreg_n;
      cnt         <= cnt_n;
      out_valid   <= (state_n != IDLE);
      frame_start <= accept;
      busy        <= (state_n != IDLE);
    end
  end

`ifdef SERIALIZER_PARITY_EN
  // Parity is captured with the word so din is free to change mid-frame.
  always_ff @(posedge clk) begin
    if (reset)       par_q <= 1'b0;
    else if (accept) par_q <= ^din;
  end
`endif

endmodule
